// File: rtl/mem_port_unit_if.sv
// ---------------------------------------------------------------------------
// mem_port_unit_if
//   External memory bus between the LC-3 MAR/MDR port unit and memory.
//
//   Handshake: mem_req acts as "valid" and is held high, together with a
//   stable mem_addr/mem_wdata/mem_we, for every cycle of an access. In
//   ack-driven mode mem_ack acts as "ready": the access completes in the
//   first cycle where mem_req && mem_ack. In fixed-latency mode mem_ack is
//   ignored and the access completes after a fixed number of cycles.
//   mem_rdata is sampled only in the completing cycle of a read.
//
//   Signals
//     mem_addr   unit -> mem  address (mirrors MAR)
//     mem_wdata  unit -> mem  write data (mirrors MDR)
//     mem_req    unit -> mem  request / valid
//     mem_we     unit -> mem  write enable, meaningful while mem_req=1
//     mem_rdata  mem  -> unit read data
//     mem_ack    mem  -> unit ready (ack-driven mode only)
// ---------------------------------------------------------------------------
interface mem_port_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_req,
    output mem_we,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_req,
    input  mem_we,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_port_unit.sv
// ---------------------------------------------------------------------------
// mem_port_unit
//   MAR/MDR memory port for the LC-3 datapath. MAR and MDR are loaded from
//   the internal bus; a small FSM runs read/write accesses to external memory
//   with either fixed wait states (HS_MODE=0) or an ack handshake with a
//   timeout (HS_MODE=1). Done pulses for one cycle on completion; Err is a
//   sticky flag set by a timeout or by Rd_Start/Wr_Start asserted together.
//
//   Ports
//     Clk        clock, rising edge
//     Reset      asynchronous active-low reset
//     BUS        internal datapath bus
//     LD_MAR     load MAR from BUS[ADDR_W-1:0] (IDLE/DONE only)
//     LD_MDR     load MDR from BUS (IDLE/DONE only)
//     Rd_Start   start a read at MAR (IDLE only)
//     Wr_Start   start a write of MDR to MAR (IDLE only)
//     Clr_Err    synchronous clear of Err (a new error in the same cycle wins)
//     MAR, MDR   address / data registers
//     Busy       access in progress
//     Done       one-cycle completion pulse
//     Err        sticky error flag
//     state_dbg  current FSM state (0 IDLE, 1 ACCESS, 2 DONE, 3 ERR)
//     mem        memory bus (master side), see mem_port_unit_if
// ---------------------------------------------------------------------------
module mem_port_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int HS_MODE     = 0,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   BUS,
  input  logic                LD_MAR,
  input  logic                LD_MDR,
  input  logic                Rd_Start,
  input  logic                Wr_Start,
  input  logic                Clr_Err,
  output logic [ADDR_W-1:0]   MAR,
  output logic [DATA_W-1:0]   MDR,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic [1:0]          state_dbg,
  mem_port_unit_if.master     mem
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  generate
    if (HS_MODE != 0 && HS_MODE != 1) begin : g_bad_hs_mode
      $error("mem_port_unit: HS_MODE must be 0 or 1");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_port_unit: WAIT_CYCLES must be in 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_port_unit: TIMEOUT must be in 1..255");
    end
    if (ADDR_W > DATA_W || ADDR_W < 1) begin : g_bad_addr_w
      $error("mem_port_unit: ADDR_W must be in 1..DATA_W");
    end
  endgenerate

  // Counter values of the last permitted ACCESS cycle in each mode.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_nx;

  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [7:0]        cnt_q;
  logic              we_q;
  logic              err_q;

  // -------------------------------------------------------------------------
  // Decode of the current state and commands
  // -------------------------------------------------------------------------
  logic in_idle;
  logic in_access;
  logic loads_open;
  logic start_rd;
  logic start_wr;
  logic start_clash;
  logic acc_finish;
  logic acc_timeout;
  logic rd_capture;
  logic err_set;

  assign in_idle     = (state_q == S_IDLE);
  assign in_access   = (state_q == S_ACCESS);
  // Register loads are blocked during ACCESS so mem_addr/mem_wdata stay
  // stable; they are also refused in ERR, which lasts a single cycle.
  assign loads_open  = in_idle | (state_q == S_DONE);
  assign start_rd    = in_idle & Rd_Start & ~Wr_Start;
  assign start_wr    = in_idle & Wr_Start & ~Rd_Start;
  assign start_clash = in_idle & Rd_Start & Wr_Start;

  // Fixed-latency mode completes on the counter; ack mode completes on ack,
  // and ack in the final allowed cycle still counts as success.
  assign acc_finish  = (HS_MODE == 0) ? (cnt_q == WAIT_LAST) : mem.mem_ack;
  assign acc_timeout = (HS_MODE != 0) & ~mem.mem_ack & (cnt_q == TO_LAST);

  assign rd_capture  = in_access & acc_finish & ~we_q;
  assign err_set     = start_clash | (in_access & acc_timeout);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_rd || start_wr) begin
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (acc_finish) begin
          state_nx = S_DONE;
        end else if (acc_timeout) begin
          state_nx = S_ERR;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    Busy        = 1'b0;
    Done        = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        Busy        = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = we_q;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg     = state_q;
  assign MAR           = mar_q;
  assign MDR           = mdr_q;
  assign Err           = err_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mar_q <= '0;
      mdr_q <= '0;
      cnt_q <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (loads_open && LD_MAR) begin
        mar_q <= BUS[ADDR_W-1:0];
      end

      // Bus loads and read capture never coincide: loads are only open
      // outside ACCESS, capture only happens inside it.
      if (loads_open && LD_MDR) begin
        mdr_q <= BUS;
      end else if (rd_capture) begin
        mdr_q <= mem.mem_rdata;
      end

      // Counts ACCESS cycles from 0; held at 0 everywhere else so it is
      // already cleared on entry.
      cnt_q <= in_access ? (cnt_q + 8'd1) : 8'd0;

      if (start_rd || start_wr) begin
        we_q <= start_wr;
      end

      if (err_set) begin
        err_q <= 1'b1;
      end else if (Clr_Err) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_port_unit
//   Two instances share one stimulus stream: u0 is fixed-latency
//   (WAIT_CYCLES=2), u1 is ack-driven (TIMEOUT=15). A transaction-level model
//   per instance predicts all outputs every cycle; directed scenarios add
//   hand-computed literal expectations (latencies, request counts, data).
// ---------------------------------------------------------------------------
module tb_mem_port_unit;

  localparam int WAIT_C = 2;
  localparam int TMO    = 15;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // -------------------------------------------------------------------------
  // Shared stimulus
  // -------------------------------------------------------------------------
  logic [15:0] bus = '0;
  logic        ld_mar = 1'b0;
  logic        ld_mdr = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] rdata = '0;
  logic        ack = 1'b0;

  mem_port_unit_if #(.DATA_W(16), .ADDR_W(16)) mif0 ();
  mem_port_unit_if #(.DATA_W(16), .ADDR_W(16)) mif1 ();
  assign mif0.mem_rdata = rdata;
  assign mif0.mem_ack   = ack;
  assign mif1.mem_rdata = rdata;
  assign mif1.mem_ack   = ack;

  logic [15:0] mar0, mdr0, mar1, mdr1;
  logic        busy0, done0, err0, busy1, done1, err1;
  logic [1:0]  st0, st1;

  mem_port_unit #(.DATA_W(16), .ADDR_W(16), .HS_MODE(0), .WAIT_CYCLES(WAIT_C), .TIMEOUT(TMO)) u0 (
    .Clk(clk), .Reset(rst_n), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .Rd_Start(rd), .Wr_Start(wr), .Clr_Err(clr), .MAR(mar0), .MDR(mdr0),
    .Busy(busy0), .Done(done0), .Err(err0), .state_dbg(st0), .mem(mif0)
  );

  mem_port_unit #(.DATA_W(16), .ADDR_W(16), .HS_MODE(1), .WAIT_CYCLES(WAIT_C), .TIMEOUT(TMO)) u1 (
    .Clk(clk), .Reset(rst_n), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .Rd_Start(rd), .Wr_Start(wr), .Clr_Err(clr), .MAR(mar1), .MDR(mdr1),
    .Busy(busy1), .Done(done1), .Err(err1), .state_dbg(st1), .mem(mif1)
  );

  // -------------------------------------------------------------------------
  // Check bookkeeping
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: k = index of the current access cycle, -1 when no
  // access is running; done_p / err_p mark the single cycle after an access.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        err;
    logic        we;
    logic        done_p;
    logic        err_p;
    int          k;
  } mdl_t;

  localparam mdl_t MDL_RST = '{mar: 16'h0, mdr: 16'h0, err: 1'b0, we: 1'b0,
                               done_p: 1'b0, err_p: 1'b0, k: -1};

  function automatic mdl_t mdl_next(input mdl_t m, input bit hs);
    mdl_t n;
    bit   err_ev;
    bit   idle;
    bit   can_load;
    bit   finish;
    n        = m;
    err_ev   = 1'b0;
    idle     = (m.k < 0) && !m.done_p && !m.err_p;
    can_load = (m.k < 0) && !m.err_p;
    n.done_p = 1'b0;
    n.err_p  = 1'b0;
    if (can_load && ld_mar) n.mar = bus;
    if (can_load && ld_mdr) n.mdr = bus;
    if (idle) begin
      if (rd && wr) begin
        err_ev = 1'b1;
      end else if (rd || wr) begin
        n.k  = 0;
        n.we = wr;
      end
    end else if (m.k >= 0) begin
      finish = hs ? ack : (m.k == WAIT_C);
      if (finish) begin
        if (!m.we) n.mdr = rdata;
        n.done_p = 1'b1;
        n.k      = -1;
      end else if (hs && m.k == TMO - 1) begin
        n.err_p = 1'b1;
        err_ev  = 1'b1;
        n.k     = -1;
      end else begin
        n.k = m.k + 1;
      end
    end
    if (err_ev) n.err = 1'b1;
    else if (clr) n.err = 1'b0;
    return n;
  endfunction

  mdl_t m0 = MDL_RST;
  mdl_t m1 = MDL_RST;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = MDL_RST;
      m1 = MDL_RST;
    end else begin
      m0 = mdl_next(m0, 1'b0);
      m1 = mdl_next(m1, 1'b1);
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard: expected MDR value at each Done pulse, per instance
  // -------------------------------------------------------------------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  int req_cnt0 = 0, req_cnt1 = 0;
  int wr_ok0 = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int done_cyc0 = 0, done_cyc1 = 0;

  task automatic check_unit(input string p, input mdl_t m,
                            input logic [15:0] mar, input logic [15:0] mdr,
                            input logic busy, input logic done, input logic err,
                            input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
    bit acc;
    acc = (m.k >= 0);
    cmp({p, ".MAR"}, mar, m.mar);
    cmp({p, ".MDR"}, mdr, m.mdr);
    cmp({p, ".Busy"}, busy, acc);
    cmp({p, ".Done"}, done, m.done_p);
    cmp({p, ".Err"}, err, m.err);
    cmp({p, ".mem_req"}, req, acc);
    cmp({p, ".mem_we"}, we, acc && m.we);
    cmp({p, ".mem_addr"}, addr, m.mar);
    cmp({p, ".mem_wdata"}, wdata, m.mdr);
  endtask

  always @(negedge clk) begin
    check_unit("u0", m0, mar0, mdr0, busy0, done0, err0,
               mif0.mem_req, mif0.mem_we, mif0.mem_addr, mif0.mem_wdata);
    check_unit("u1", m1, mar1, mdr1, busy1, done1, err1,
               mif1.mem_req, mif1.mem_we, mif1.mem_addr, mif1.mem_wdata);
    if (mif0.mem_req) req_cnt0++;
    if (mif1.mem_req) req_cnt1++;
    if (mif0.mem_req && mif0.mem_we && mif0.mem_wdata == 16'h1234) wr_ok0++;
    if (done0) begin
      done_cnt0++;
      done_cyc0 = cyc;
      if (exp_q0.size() == 0) cmp("u0.done_unexpected", {31'b0, done0}, 32'd0);
      else cmp("u0.read_data", mdr0, exp_q0.pop_front());
    end
    if (done1) begin
      done_cnt1++;
      done_cyc1 = cyc;
      if (exp_q1.size() == 0) cmp("u1.done_unexpected", {31'b0, done1}, 32'd0);
      else cmp("u1.read_data", mdr1, exp_q1.pop_front());
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks: inputs change 1 time unit after the falling edge and hold
  // for one full clock cycle.
  // -------------------------------------------------------------------------
  task automatic drive(input logic [15:0] b, input logic lm, input logic ld,
                       input logic r, input logic w, input logic c);
    bus = b; ld_mar = lm; ld_mdr = ld; rd = r; wr = w; clr = c;
    @(negedge clk); #1;
    ld_mar = 1'b0; ld_mdr = 1'b0; rd = 1'b0; wr = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  int t_start;
  int snap0, snap1, dsnap0, dsnap1;

  initial begin
    // Reset state
    idle(2);
    cmp("reset.u0.MAR", mar0, 16'h0000);
    cmp("reset.u1.MDR", mdr1, 16'h0000);
    cmp("reset.u0.Err", err0, 1'b0);
    cmp("reset.u1.mem_req", mif1.mem_req, 1'b0);
    cmp("reset.u0.state", st0, 2'd0);
    rst_n = 1'b1;
    idle(1);

    // T1: read 0x3000; u1 sees ack already high, so completes in cycle k=0
    ack = 1'b1;
    rdata = 16'hBEEF;
    drive(16'h3000, 1, 0, 0, 0, 0);
    exp_q0.push_back(16'hBEEF);
    exp_q1.push_back(16'hBEEF);
    snap0 = req_cnt0; snap1 = req_cnt1;
    t_start = cyc;
    drive(16'h0000, 0, 0, 1, 0, 0);
    idle(6);
    cmp("t1.u0.req_cycles", req_cnt0 - snap0, 3);
    cmp("t1.u0.done_latency", done_cyc0 - t_start, 4);
    cmp("t1.u0.MDR", mdr0, 16'hBEEF);
    cmp("t1.u1.req_cycles", req_cnt1 - snap1, 1);
    cmp("t1.u1.done_latency", done_cyc1 - t_start, 2);
    cmp("t1.u0.done_count", done_cnt0, 1);

    // T2: write 0x1234 to 0x0010
    drive(16'h0010, 1, 0, 0, 0, 0);
    drive(16'h1234, 0, 1, 0, 0, 0);
    exp_q0.push_back(16'h1234);
    exp_q1.push_back(16'h1234);
    snap0 = req_cnt0; dsnap0 = done_cnt0;
    drive(16'h0000, 0, 0, 0, 1, 0);
    idle(6);
    cmp("t2.u0.req_cycles", req_cnt0 - snap0, 3);
    cmp("t2.u0.we_wdata_cycles", wr_ok0, 3);
    cmp("t2.u0.done_count", done_cnt0 - dsnap0, 1);
    cmp("t2.u0.MDR", mdr0, 16'h1234);
    cmp("t2.u0.MAR", mar0, 16'h0010);

    // T3: ack in the 5th request cycle; LD_MAR during access is ignored
    drive(16'h3000, 1, 0, 0, 0, 0);
    ack = 1'b0;
    rdata = 16'hA5A5;
    exp_q0.push_back(16'hA5A5);
    exp_q1.push_back(16'hA5A5);
    snap1 = req_cnt1;
    t_start = cyc;
    drive(16'h0000, 0, 0, 1, 0, 0);
    drive(16'hFFFF, 1, 0, 0, 0, 0);
    idle(3);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(4);
    cmp("t3.u1.done_latency", done_cyc1 - t_start, 6);
    cmp("t3.u1.req_cycles", req_cnt1 - snap1, 5);
    cmp("t3.u1.MDR", mdr1, 16'hA5A5);
    cmp("t3.u1.MAR", mar1, 16'h3000);
    cmp("t3.u0.MAR", mar0, 16'h3000);
    cmp("t3.u1.Err", err1, 1'b0);

    // T4: u1 times out after 15 request cycles; u0 reads normally
    rdata = 16'h5555;
    exp_q0.push_back(16'h5555);
    snap1 = req_cnt1; dsnap1 = done_cnt1;
    drive(16'h0000, 0, 0, 1, 0, 0);
    idle(20);
    cmp("t4.u1.req_cycles", req_cnt1 - snap1, 15);
    cmp("t4.u1.Err", err1, 1'b1);
    cmp("t4.u1.no_done", done_cnt1 - dsnap1, 0);
    cmp("t4.u1.MDR", mdr1, 16'hA5A5);
    cmp("t4.u0.MDR", mdr0, 16'h5555);
    drive(16'h0000, 0, 0, 0, 0, 1);
    cmp("t4.u1.Err_cleared", err1, 1'b0);

    // T5: Rd_Start+Wr_Start together, with Clr_Err: error wins, no access
    snap0 = req_cnt0; snap1 = req_cnt1;
    drive(16'h0000, 0, 0, 1, 1, 1);
    cmp("t5.u0.Err", err0, 1'b1);
    cmp("t5.u1.Err", err1, 1'b1);
    idle(3);
    cmp("t5.u0.no_req", req_cnt0 - snap0, 0);
    cmp("t5.u1.no_req", req_cnt1 - snap1, 0);
    drive(16'h0000, 0, 0, 0, 0, 1);

    // T6: reset in the 2nd access cycle of a read
    drive(16'h3000, 1, 0, 0, 0, 0);
    dsnap0 = done_cnt0; dsnap1 = done_cnt1;
    drive(16'h0000, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("t6.u0.mem_req", mif0.mem_req, 1'b0);
    cmp("t6.u1.mem_req", mif1.mem_req, 1'b0);
    cmp("t6.u0.Busy", busy0, 1'b0);
    cmp("t6.u1.Busy", busy1, 1'b0);
    cmp("t6.u0.MAR", mar0, 16'h0000);
    cmp("t6.u1.MAR", mar1, 16'h0000);
    cmp("t6.u0.MDR", mdr0, 16'h0000);
    cmp("t6.u1.MDR", mdr1, 16'h0000);
    @(negedge clk); #1;
    idle(1);
    rst_n = 1'b1;
    idle(8);
    cmp("t6.u0.no_done", done_cnt0 - dsnap0, 0);
    cmp("t6.u1.no_done", done_cnt1 - dsnap1, 0);
    cmp("t6.u0.state", st0, 2'd0);
    cmp("t6.u1.state", st1, 2'd0);

    // Every expected completion must have been seen
    cmp("final.u0.pending", exp_q0.size(), 0);
    cmp("final.u1.pending", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
